// File: rtl/ram_scan_reader_if.sv
// Scan reader bus: RAM read port, control inputs and display outputs.
// master = scan reader, slave = RAM/display/control side.
interface ram_scan_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);
    logic              enable;
    logic              step;
    logic              refresh;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;

    modport master (
        input  enable, step, refresh, rd_data,
        output rd_addr, rd_en, disp_addr, disp_data, disp_valid
    );

    modport slave (
        output enable, step, refresh, rd_data,
        input  rd_addr, rd_en, disp_addr, disp_data, disp_valid
    );
endinterface

// File: rtl/ram_scan_reader.sv
// Walks the RAM one word at a time and holds a matched
// address/data pair for the HEX display.
module ram_scan_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = 1
) (
    input logic             clk,
    input logic             reset_n,
    ram_scan_reader_if.master bus
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        INIT,
        READ,
        WAIT,
        HOLD
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_tick_cnt;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic              r_refresh_pend;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_disp_addr;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_disp_valid;
    logic              w_adv;

    assign w_adv = (bus.enable && (r_tick_cnt == TICK_MAX)) ||
                   (!bus.enable && bus.step);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= INIT;
            r_tick_cnt     <= '0;
            r_lat_cnt      <= '0;
            r_refresh_pend <= 1'b0;
            r_rd_addr      <= '0;
            r_rd_en        <= 1'b0;
            r_disp_addr    <= '0;
            r_disp_data    <= '0;
            r_disp_valid   <= 1'b0;
        end else begin
            r_rd_en <= 1'b0;
            if (bus.enable && (r_tick_cnt != TICK_MAX)) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            unique case (r_state)
                INIT: begin
                    if (bus.refresh) r_refresh_pend <= 1'b1;
                    r_rd_en <= 1'b1;
                    r_state <= READ;
                end
                READ: begin
                    if (bus.refresh) r_refresh_pend <= 1'b1;
                    r_lat_cnt <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (bus.refresh) r_refresh_pend <= 1'b1;
                    r_lat_cnt <= r_lat_cnt + 1'b1;
                    if (r_lat_cnt == LAT_MAX) begin
                        r_disp_data  <= bus.rd_data;
                        r_disp_addr  <= r_rd_addr;
                        r_disp_valid <= 1'b1;
                        r_state      <= HOLD;
                    end
                end
                HOLD: begin
                    // An advance supersedes any refresh: the new word is read anyway.
                    if (w_adv) begin
                        r_rd_addr      <= r_rd_addr + 1'b1;
                        r_tick_cnt     <= '0;
                        r_refresh_pend <= 1'b0;
                        r_rd_en        <= 1'b1;
                        r_state        <= READ;
                    end else if (bus.refresh || r_refresh_pend) begin
                        r_refresh_pend <= 1'b0;
                        r_rd_en        <= 1'b1;
                        r_state        <= READ;
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    assign bus.rd_addr    = r_rd_addr;
    assign bus.rd_en      = r_rd_en;
    assign bus.disp_addr  = r_disp_addr;
    assign bus.disp_data  = r_disp_data;
    assign bus.disp_valid = r_disp_valid;
endmodule
